uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one uart_tx transmitter among NUM_REQ byte producers (e.g. command, status, debug, loopback sources). It accepts one byte at a time over a per-requester valid/ready handshake and launches it with a single-cycle start pulse. It then holds the transmitter until done_tx, or until a watchdog timeout. It sits beside uart_tx inside the uart top level and drives start and tx_data_in in place of the top-level ports.

---
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx among NUM_REQ byte producers.
// Each grant launches one byte and holds the transmitter until done_tx or a watchdog abort.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 32768,
    parameter int unsigned TMR_W          = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [8*NUM_REQ-1:0]       req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       start,
    output logic [7:0]                 tx_data_in,
    input  logic                       tx_active,
    input  logic                       done_tx,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       busy,
    output logic                       timeout_err
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        WAIT_DONE
    } state_t;

    state_t           r_state;
    logic [TMR_W-1:0] r_timer;
    logic [IDW-1:0]   r_rr_ptr;

    logic             w_found;
    logic [IDW-1:0]   w_win;
    logic [IDW-1:0]   w_cand;
    logic [7:0]       w_bytes [NUM_REQ];
    logic             w_unused;

    // tx_active is informational only; sequencing relies solely on done_tx.
    assign w_unused = tx_active;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_bytes[g] = req_data[8*g +: 8];
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = r_rr_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
            w_cand = (w_cand == IDW'(NUM_REQ - 1)) ? '0 : w_cand + 1'b1;
        end
    end

    assign busy = (r_state == WAIT_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_timer     <= '0;
            r_rr_ptr    <= '0;
            start       <= 1'b0;
            req_ready   <= '0;
            tx_data_in  <= '0;
            grant_id    <= '0;
            timeout_err <= 1'b0;
        end else begin
            start       <= 1'b0;
            req_ready   <= '0;
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        tx_data_in <= w_bytes[w_win];
                        grant_id   <= w_win;
                        req_ready  <= NUM_REQ'(1) << w_win;
                        start      <= 1'b1;
                        r_rr_ptr   <= (w_win == IDW'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
                        r_timer    <= '0;
                        r_state    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    r_timer <= r_timer + 1'b1;
                    // done_tx takes priority over a coincident watchdog expiry.
                    if (done_tx) begin
                        r_state <= IDLE;
                    end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus queues expected grants, a monitor checks
// each start pulse and frame end, and a stub answers with done_tx after a per-frame delay.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           start;
    logic [7:0]     tx_data_in;
    logic           tx_active;
    logic           done_tx;
    logic [1:0]     grant_id;
    logic           busy;
    logic           timeout_err;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        int         dly;   // 0: no done_tx, frame must time out
    } exp_t;

    exp_t exp_q [$];
    int   dly_q [$];
    int   checks      = 0;
    int   failures    = 0;
    int   start_count = 0;
    int   rst_epoch   = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .TIMEOUT_CYCLES(TO),
        .TMR_W         (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .start      (start),
        .tx_data_in (tx_data_in),
        .tx_active  (tx_active),
        .done_tx    (done_tx),
        .grant_id   (grant_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;
    assign tx_active = busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] d, input int dly);
        exp_t e;
        e.id   = id;
        e.data = d;
        e.dly  = dly;
        exp_q.push_back(e);
        dly_q.push_back(dly);
    endtask

    task automatic drive(input logic [N-1:0] mask);
        int n = 0;
        req_valid = req_valid | mask;
        while ((req_valid & mask) != '0 && n < 300) begin
            @(posedge clk); #2;
            req_valid = req_valid & ~req_ready;
            n++;
        end
        check("accept_in_time", 32'(req_valid & mask), 32'(0));
    endtask

    task automatic wait_starts(input int target);
        int n = 0;
        while (start_count < target && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check("starts_reached", start_count, target);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(posedge clk); #2;
            n++;
        end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},       32'(start),       32'(0));
        check({tag, "_req_ready"},   32'(req_ready),   32'(0));
        check({tag, "_tx_data_in"},  32'(tx_data_in),  32'(0));
        check({tag, "_grant_id"},    32'(grant_id),    32'(0));
        check({tag, "_busy"},        32'(busy),        32'(0));
        check({tag, "_timeout_err"}, 32'(timeout_err), 32'(0));
    endtask

    // done_tx stub: pulses done_tx in cycle 'dly' after the start cycle.
    initial begin : stub
        int d;
        int ep;
        done_tx = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst && start) begin
                d  = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
                ep = rst_epoch;
                if (d > 0) begin
                    for (int i = 0; i < d; i++) begin
                        @(posedge clk);
                        if (ep != rst_epoch) break;
                    end
                    if (ep == rst_epoch) begin
                        #1 done_tx = 1'b1;
                        @(posedge clk); #1 done_tx = 1'b0;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t cur;
        int   cnt;
        logic in_frame;
        logic prev_start;
        logic prev_busy;
        cnt        = 0;
        in_frame   = 1'b0;
        prev_start = 1'b0;
        prev_busy  = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                in_frame   = 1'b0;
                prev_start = 1'b0;
                prev_busy  = 1'b0;
            end else begin
                if (start) begin
                    start_count++;
                    check("no_back_to_back_start", 32'(prev_start), 32'(0));
                    if (exp_q.size() == 0) begin
                        check("start_without_request", 32'(start), 32'(0));
                        in_frame = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        check("grant_id",   32'(grant_id),   32'(cur.id));
                        check("tx_data_in", 32'(tx_data_in), 32'(cur.data));
                        check("req_ready",  32'(req_ready),  32'(4'(1) << cur.id));
                        check("busy_rise",  32'(busy),       32'(1));
                        in_frame = 1'b1;
                        cnt      = 0;
                    end
                end else if (in_frame) begin
                    cnt++;
                    if (cnt == 1) begin
                        check("req_ready_one_cycle", 32'(req_ready), 32'(0));
                        check("busy_held",           32'(busy),      32'(1));
                    end
                    if (prev_busy && !busy) begin
                        check("frame_end_cycle", cnt, (cur.dly == 0) ? TO : 32'(cur.dly + 1));
                        check("timeout_err_at_end", 32'(timeout_err), 32'(cur.dly == 0));
                        in_frame = 1'b0;
                    end else if (timeout_err) begin
                        check("spurious_timeout", 32'(timeout_err), 32'(0));
                    end else if (cnt > int'(TO) + 4) begin
                        check("frame_stuck_busy", 32'(busy), 32'(0));
                        in_frame = 1'b0;
                    end
                end else if (timeout_err) begin
                    check("timeout_while_idle", 32'(timeout_err), 32'(0));
                end
                prev_start = start;
                prev_busy  = busy;
            end
        end
    end

    initial begin : stim
        int base;
        rst       = 1'b0;
        req_valid = '0;
        req_data  = '0;
        repeat (2) @(posedge clk); #1;
        check_reset_outputs("por");
        #1 rst = 1'b1;
        repeat (2) @(posedge clk); #2;

        // single requester 0
        req_data[7:0] = 8'h55;
        push(2'd0, 8'h55, 8);
        drive(4'b0001);
        wait_idle();

        // mid-simulation reset with no requests pending
        @(posedge clk); #3;
        rst_epoch++;
        rst = 1'b0;
        #1 check_reset_outputs("mid_rst");
        repeat (2) @(posedge clk); #2 rst = 1'b1;
        base = start_count;
        repeat (100) @(posedge clk);
        #2 check("no_start_while_idle", start_count - base, 0);

        // all four held valid: 0,1,2,3,0
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'hA0 + 8'(i);
        push(2'd0, 8'hA0, 8);
        push(2'd1, 8'hA1, 8);
        push(2'd2, 8'hA2, 8);
        push(2'd3, 8'hA3, 8);
        push(2'd0, 8'hA0, 8);
        base = start_count;
        req_valid = 4'b1111;
        wait_starts(base + 5);
        req_valid = '0;
        wait_idle();

        // grant 1 (rr_ptr -> 2), then 1001 must give 3 then 0
        req_data[15:8] = 8'h5A;
        push(2'd1, 8'h5A, 8);
        drive(4'b0010);
        wait_idle();
        req_data[31:24] = 8'hD3;
        req_data[7:0]   = 8'hD0;
        push(2'd3, 8'hD3, 8);
        push(2'd0, 8'hD0, 8);
        drive(4'b1001);
        wait_idle();

        // watchdog: grant 2 times out, pending requester 0 follows
        req_data[23:16] = 8'hC2;
        req_data[7:0]   = 8'hC0;
        push(2'd2, 8'hC2, 0);
        push(2'd0, 8'hC0, 8);
        drive(4'b0101);
        wait_idle();

        // done_tx on the last timer cycle beats the watchdog
        req_data[15:8] = 8'h3C;
        push(2'd1, 8'h3C, 15);
        drive(4'b0010);
        wait_idle();

        // reset during WAIT_DONE, then rr_ptr must restart from 0
        req_data[23:16] = 8'h77;
        push(2'd2, 8'h77, 8);
        drive(4'b0100);
        repeat (3) @(posedge clk); #4;
        rst_epoch++;
        rst = 1'b0;
        #1 check_reset_outputs("frame_rst");
        repeat (3) @(posedge clk); #2 rst = 1'b1;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = 8'hE0 + 8'(i);
        push(2'd0, 8'hE0, 4);
        push(2'd1, 8'hE1, 4);
        push(2'd2, 8'hE2, 4);
        push(2'd3, 8'hE3, 4);
        drive(4'b1111);
        wait_idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
